ones_pattern_serializer: RTL and testbench

- Inverse of the team's 15-input ones-counter datapath.
- Accepts a 4-bit ones count and regenerates a 15-bit word holding exactly that many ones, packed from index 0 upward (thermometer order).
- Shifts the word out serially, one bit per clock, and also exposes it in parallel at completion.
- Used as a stimulus source and as a round-trip checker feeding the ones-counter under test.

---
 rtl/ones_pattern_serializer_if.sv | 25 ++
 rtl/ones_pattern_serializer.sv | 85 ++++++++
 tb/tb_ones_pattern_serializer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ones_pattern_serializer_if.sv
// Handshake and data bundle between a pattern requester and ones_pattern_serializer.
// The master issues start/count. The slave returns the serial stream and the parallel word.
interface ones_pattern_serializer_if #(
    parameter int WIDTH = 15,
    parameter int CW    = 4
);
    logic             start;
    logic [CW-1:0]    count;
    logic             busy;
    logic             bit_out;
    logic             bit_valid;
    logic [CW-1:0]    bit_idx;
    logic [WIDTH-1:0] word;
    logic             done;

    modport master (
        output start, count,
        input  busy, bit_out, bit_valid, bit_idx, word, done
    );

    modport slave (
        input  start, count,
        output busy, bit_out, bit_valid, bit_idx, word, done
    );
endinterface

// File: rtl/ones_pattern_serializer.sv
// Regenerates a thermometer-coded word holding `count` ones (packed from bit 0).
// The word is shifted out one bit per clock and also exposed in parallel when done.
module ones_pattern_serializer #(
    parameter int WIDTH = 15,
    parameter int CW    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    ones_pattern_serializer_if.slave bus
);

    localparam logic [CW-1:0] MAX_N = CW'(WIDTH);
    localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] n;
    logic [CW-1:0] n_next;
    logic [CW-1:0] idx_inc;

    // Counts beyond the word length saturate to an all-ones word.
    assign n_next  = (bus.count > MAX_N) ? MAX_N : bus.count;
    assign idx_inc = bus.bit_idx + 1'b1;

    // NOTE: all state and outputs use non-blocking assignments so every register
    // samples pre-edge values; blocking here would chain bit_idx into bit_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            n             <= '0;
            bus.busy      <= 1'b0;
            bus.bit_out   <= 1'b0;
            bus.bit_valid <= 1'b0;
            bus.bit_idx   <= '0;
            bus.word      <= '0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state         <= SHIFT;
                        n             <= n_next;
                        bus.bit_idx   <= '0;
                        bus.word      <= '0;
                        bus.busy      <= 1'b1;
                        bus.bit_valid <= 1'b1;
                        bus.bit_out   <= (n_next != '0);
                    end else begin
                        state <= IDLE;
                    end
                end

                SHIFT: begin
                    bus.word[bus.bit_idx] <= bus.bit_out;
                    if (bus.bit_idx == LAST) begin
                        state         <= DONE;
                        bus.busy      <= 1'b0;
                        bus.bit_valid <= 1'b0;
                        bus.bit_out   <= 1'b0;
                        bus.bit_idx   <= '0;
                        bus.done      <= 1'b1;
                    end else begin
                        bus.bit_idx <= idx_inc;
                        bus.bit_out <= (idx_inc < n);
                    end
                end

                default: begin
                    state         <= IDLE;
                    bus.busy      <= 1'b0;
                    bus.bit_valid <= 1'b0;
                    bus.bit_out   <= 1'b0;
                    bus.bit_idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ones_pattern_serializer.sv
// Directed bench for ones_pattern_serializer: serial stream, parallel word, re-arm,
// ignored start during shift, asynchronous abort and a popcount loop-back sweep.
module tb_ones_pattern_serializer;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ones_pattern_serializer_if #(.WIDTH(15), .CW(4)) bus ();

    ones_pattern_serializer #(.WIDTH(15), .CW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},  32'(bus.busy),      0);
        check({tag, "_valid"}, 32'(bus.bit_valid), 0);
        check({tag, "_bit"},   32'(bus.bit_out),   0);
        check({tag, "_idx"},   32'(bus.bit_idx),   0);
        check({tag, "_done"},  32'(bus.done),      0);
    endtask

    // Requests a transfer and checks every serial slot plus the done cycle.
    // With noise set, start is held high with a different count during SHIFT.
    task automatic run_xfer(input logic [3:0] c, input logic [14:0] exp_word, input bit noise);
        bus.start = 1'b1;
        bus.count = c;
        tick();
        bus.start = noise;
        bus.count = noise ? 4'd9 : c;
        for (int i = 0; i < 15; i++) begin
            check("shift_busy",  32'(bus.busy),      1);
            check("shift_valid", 32'(bus.bit_valid), 1);
            check("shift_idx",   32'(bus.bit_idx),   i);
            check("shift_bit",   32'(bus.bit_out),   32'(exp_word[i]));
            check("shift_done",  32'(bus.done),      0);
            if (i == 14) bus.start = 1'b0;
            tick();
        end
        check("done_pulse", 32'(bus.done),      1);
        check("done_busy",  32'(bus.busy),      0);
        check("done_valid", 32'(bus.bit_valid), 0);
        check("done_bit",   32'(bus.bit_out),   0);
        check("done_idx",   32'(bus.bit_idx),   0);
        check("done_word",  32'(bus.word),      32'(exp_word));
    endtask

    // Ones-counter model on the parallel word, with a bounded wait for done.
    task automatic loop_back(input int c);
        int cyc = 0;
        bus.start = 1'b1;
        bus.count = c[3:0];
        tick();
        bus.start = 1'b0;
        while (!bus.done && cyc < 40) begin
            tick();
            cyc++;
        end
        check("lb_done_seen", 32'(bus.done), 1);
        check("lb_latency",   32'(cyc), 15);
        check("lb_popcount",  32'($countones(bus.word)), 32'(c));
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.count = 4'd0;
        #12;
        check_quiet("reset");
        check("reset_word", 32'(bus.word), 0);
        rst = 1'b0;
        tick();
        check_quiet("idle");

        // count=5: index 0 first, five ones then ten zeros
        run_xfer(4'd5, 15'h001F, 1'b0);
        tick();
        check("idle_after_done", 32'(bus.done), 0);
        check("idle_word_hold",  32'(bus.word), 32'h001F);

        run_xfer(4'd0,  15'h0000, 1'b0);
        tick();
        run_xfer(4'd15, 15'h7FFF, 1'b0);
        tick();

        // second request with count=9 during SHIFT must be ignored
        run_xfer(4'd3, 15'h0007, 1'b1);
        tick();
        check_quiet("after_ignored");

        // re-arm in the DONE cycle: no IDLE gap
        run_xfer(4'd2, 15'h0003, 1'b0);
        run_xfer(4'd7, 15'h007F, 1'b0);
        tick();

        // asynchronous abort at bit_idx=6 of a count=10 transfer
        bus.start = 1'b1;
        bus.count = 4'd10;
        tick();
        bus.start = 1'b0;
        repeat (6) tick();
        check("abort_pre_idx",  32'(bus.bit_idx), 6);
        check("abort_pre_word", 32'(bus.word),    32'h003F);
        rst = 1'b1;
        #1;
        check_quiet("abort");
        check("abort_word", 32'(bus.word), 0);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("abort_no_done", 32'(bus.done), 0);
            check("abort_no_busy", 32'(bus.busy), 0);
        end
        run_xfer(4'd4, 15'h000F, 1'b0);
        tick();

        for (int c = 0; c < 16; c++) loop_back(c);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
